// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl -- multi-cycle control unit for a small 8-bit CPU.
//
// Runs each instruction through FETCH -> DECODE -> EXEC and then, depending
// on the opcode, MEM and/or WB before fetching again. It owns the program
// counter, the instruction register and the exception PC. It drives the
// fetch, data-memory and register-file write strobes.
//
// Optional feature, controlled by macro OVF_TRAP_EN:
//   defined   - opcode 0001 (add) that overflows at EXEC skips write-back.
//               The FSM enters TRAP, records epc, jumps to TRAP_VEC and
//               pulses trap for one cycle.
//   undefined - alu_ovf is ignored, there is no TRAP state, and trap and epc
//               are tied to zero.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   TRAP_VEC   PC loaded on an overflow trap
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   run                execution enable, sampled whenever FETCH would be entered
//   imem_req/addr      instruction fetch request and address (= pc)
//   imem_ack/rdata     fetch complete, fetched instruction
//   ir, pc             instruction register, program counter (feed the ALU)
//   alu_out            ALU result (jump offset for 1000 / jump-and-link)
//   alu_jump           branch condition, 8'hFF = taken
//   alu_ovf            ALU overflow
//   dmem_req/we/ack    data memory request, store flag, access complete
//   rf_we, wb_sel      register-file write strobe, write-back source
//                      (00 ALU, 01 memory, 10 link = pc+1)
//   trap, epc          one-cycle trap pulse, PC of the trapping instruction
// -----------------------------------------------------------------------------
module cpu_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] TRAP_VEC = 8'hF0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_rdata,
    output logic [7:0] ir,
    output logic [7:0] pc,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_jump,
    input  logic       alu_ovf,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [7:0] epc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef OVF_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JAL  = 4'b1001;
    localparam logic [3:0] OP_LD   = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1011;
    localparam logic [3:0] OP_BR0  = 4'b1100;
    localparam logic [3:0] OP_BR1  = 4'b1101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    state_t     state;
    state_t     state_next;
    state_t     fetch_or_idle;
    logic [3:0] opcode;
    logic [7:0] pc_inc;
    logic [7:0] br_ofs;
    logic [7:0] link_ofs;   // alu_out captured at EXEC, used by jump-and-link in WB
    logic       ovf_trap;

    assign opcode    = ir[7:4];
    assign pc_inc    = pc + 8'd1;            // 8-bit result wraps FF -> 00
    assign br_ofs    = {{4{ir[3]}}, ir[3:0]};
    assign imem_addr = pc;

`ifdef OVF_TRAP_EN
    assign ovf_trap = (opcode == OP_ADD) && alu_ovf;
`else
    logic unused_ok;
    assign ovf_trap  = 1'b0;
    assign epc       = 8'h00;
    assign unused_ok = ^{alu_ovf, TRAP_VEC};
`endif

    // run only matters when the FSM is about to (re)enter FETCH; otherwise
    // the instruction in flight always completes.
    assign fetch_or_idle = run ? S_FETCH : S_IDLE;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // ----------------------------------------------------------- next state
    // NOTE: the default assignment at the top of a combinational block keeps
    // every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  if (imem_ack) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (ovf_trap) begin
`ifdef OVF_TRAP_EN
                    state_next = S_TRAP;
`endif
                end else begin
                    case (opcode)
                        OP_JMP, OP_BR0, OP_BR1: state_next = fetch_or_idle;
                        OP_LD, OP_ST:           state_next = S_MEM;
                        default:                state_next = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (dmem_ack) state_next = (opcode == OP_ST) ? fetch_or_idle : S_WB;
            end
            S_WB:     state_next = fetch_or_idle;
`ifdef OVF_TRAP_EN
            S_TRAP:   state_next = fetch_or_idle;
`endif
            default:  state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Strobes decode straight from state, so an asynchronous reset drops
    // them in the same cycle and aborts any outstanding request.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        trap     = 1'b0;
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_ST);
            end
            S_WB: begin
                rf_we = 1'b1;
                if (opcode == OP_JAL)     wb_sel = WB_LINK;
                else if (opcode == OP_LD) wb_sel = WB_MEM;
                else                      wb_sel = WB_ALU;
            end
`ifdef OVF_TRAP_EN
            S_TRAP:  trap = 1'b1;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= 8'h00;
            link_ofs <= 8'h00;
        end else begin
            case (state)
                S_FETCH: if (imem_ack) ir <= imem_rdata;
                S_EXEC: begin
                    link_ofs <= alu_out;
                    if (ovf_trap) begin
                        pc <= TRAP_VEC;
                    end else begin
                        case (opcode)
                            OP_JMP:         pc <= pc_inc + alu_out;
                            OP_BR0, OP_BR1: pc <= (alu_jump == 8'hFF) ? pc_inc + br_ofs : pc_inc;
                            default:        ;
                        endcase
                    end
                end
                S_MEM:   if (dmem_ack && (opcode == OP_ST)) pc <= pc_inc;
                S_WB:    pc <= (opcode == OP_JAL) ? pc_inc + link_ofs : pc_inc;
                default: ;
            endcase
        end
    end

`ifdef OVF_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           epc <= 8'h00;
        else if (state == S_EXEC && ovf_trap) epc <= pc;
    end
`endif

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, as the PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VEC, default 8'hF0, as the overflow trap target PC.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1 bit: execution enable.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-007 SHALL have port imem_addr, output, 8 bits: fetch address, equal to pc.
REQ-008 SHALL have port imem_ack, input, 1 bit: fetch data valid.
REQ-009 SHALL have port imem_rdata, input, 8 bits: fetched instruction.
REQ-010 SHALL have port ir, output, 8 bits: instruction register, driving the ALU instruction input.
REQ-011 SHALL have port pc, output, 8 bits: program counter, driving the ALU pc input.
REQ-012 SHALL have port alu_out, input, 8 bits: ALU result.
REQ-013 SHALL have port alu_jump, input, 8 bits: ALU jump flag; 8'hFF means taken.
REQ-014 SHALL have port alu_ovf, input, 1 bit: ALU overflow.
REQ-015 SHALL have ports dmem_req (output, 1 bit: data memory request) and dmem_we (output, 1 bit: 1 for store).
REQ-016 SHALL have port dmem_ack, input, 1 bit: data access complete.
REQ-017 SHALL have ports rf_we (output, 1 bit: register-file write strobe) and wb_sel (output, 2 bits: 00 ALU, 01 memory, 10 link = pc+1).
REQ-018 SHALL have ports trap (output, 1 bit: one-cycle trap pulse) and epc (output, 8 bits: PC of the trapping instruction).

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; opcode = ir[7:4].
REQ-020 IDLE SHALL go to FETCH when run=1, else stay.
REQ-021 FETCH SHALL hold imem_req=1 until imem_ack=1, load ir<=imem_rdata on the ack cycle, then go to DECODE; with no ack it waits indefinitely.
REQ-022 DECODE SHALL last 1 cycle and always go to EXEC.
REQ-023 EXEC SHALL last 1 cycle; alu_out, alu_jump and alu_ovf are sampled at its closing edge.
REQ-024 From EXEC, opcodes 0000-0111, 1110 and 1111 SHALL go to WB with wb_sel=00.
REQ-025 From EXEC, opcode 1001 (jump-and-link) SHALL go to WB with wb_sel=10.
REQ-026 From EXEC, opcodes 1010 and 1011 SHALL go to MEM with dmem_we = (opcode==1011).
REQ-027 MEM SHALL hold dmem_req=1 until dmem_ack=1; load then goes to WB (wb_sel=01), store goes to FETCH with pc<=pc+1.
REQ-028 Opcode 1000 SHALL go from EXEC to FETCH with pc<=pc+1+alu_out.
REQ-029 Opcodes 1100/1101 SHALL go from EXEC to FETCH with pc<=pc+1+sext(ir[3:0]) if alu_jump==8'hFF, else pc<=pc+1.
REQ-030 WB SHALL assert rf_we for exactly 1 cycle and set pc<=pc+1, except jump-and-link, which sets pc<=pc+1+alu_out; it then goes to FETCH.
REQ-031 All PC arithmetic SHALL be modulo 256: 8'hFF+1 wraps to 8'h00.
REQ-032 run=0 SHALL be checked only on entry to FETCH: the current instruction completes, then the FSM enters IDLE without a fetch.
REQ-033 rf_we, dmem_req, imem_req and trap SHALL be zero in every state other than the one that asserts them.
REQ-034 Latency SHALL be, with zero-wait acks: ALU/link ops 4 cycles FETCH-to-FETCH, load 5, store 4, jump/branch 3.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, ir=8'h00, epc=8'h00 and all strobes to 0, including mid-FETCH or mid-MEM, aborting any outstanding request.

Configuration
REQ-036 Macro OVF_TRAP_EN defined: opcode 0001 with alu_ovf=1 at EXEC SHALL skip WB (no rf_we), enter TRAP, set epc<=pc, pc<=TRAP_VEC, pulse trap=1 for 1 cycle, then go to FETCH.
REQ-037 Macro OVF_TRAP_EN undefined: alu_ovf SHALL be ignored, the TRAP state SHALL be absent, and trap and epc SHALL be tied to 0.

Verification
REQ-038 Reset then run=1, pc=00, imem returns 8'h1D with immediate ack -> rf_we pulses once with wb_sel=00, pc=01, next fetch 4 cycles after the first.
REQ-039 ir=8'hC5 at pc=10, alu_jump=FF -> pc=16; same with alu_jump=00 -> pc=11; no rf_we in either case.
REQ-040 Load 8'hA0 with dmem_ack delayed 3 cycles -> dmem_req high for exactly 4 cycles with dmem_we=0, then rf_we with wb_sel=01.
REQ-041 Jump-and-link at pc=FE, alu_out=03 -> rf_we with wb_sel=10, pc wraps to 02.
REQ-042 OVF_TRAP_EN defined, add at pc=20 with alu_ovf=1 -> no rf_we, trap pulses once, epc=20, pc=F0; undefined -> normal WB.
REQ-043 rst_n low during MEM wait -> dmem_req drops within the same cycle, state IDLE, pc=RESET_PC.
